// File: rtl/vram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : vram_arb_pkg
// Brief   : Shared types and default widths for the VRAM port arbiter.
// Revision: 1.0 - initial release
// ============================================================================
package vram_arb_pkg;

    localparam int unsigned c_ADDR_W_DEFAULT = 16;
    localparam int unsigned c_DATA_W_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        BUSY_DISP = 2'd1,
        BUSY_CPU  = 2'd2,
        COOL      = 2'd3
    } arb_state_e;

    typedef enum logic {
        SEL_DISP = 1'b0,
        SEL_CPU  = 1'b1
    } arb_sel_e;

endpackage
`default_nettype wire

// File: rtl/arb_watchdog.sv
`default_nettype none
// ============================================================================
// Module  : arb_watchdog
// Brief   : Transaction cycle counter; flags the TIMEOUT-th enabled cycle.
// Revision: 1.0 - initial release
// ============================================================================
module arb_watchdog #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int unsigned          c_CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [c_CNT_W-1:0]   c_LAST  = c_CNT_W'(TIMEOUT - 1);

    logic [c_CNT_W-1:0] r_count;

    // r_count holds the number of enabled cycles already elapsed
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != c_LAST)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expired = i_enable && (r_count == c_LAST);

endmodule
`default_nettype wire

// File: rtl/vram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : vram_port_arbiter
// Brief   : Display-priority arbiter with bounded CPU starvation and watchdog.
// Revision: 1.0 - initial release
// ============================================================================
module vram_port_arbiter
    import vram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W       = c_ADDR_W_DEFAULT,
    parameter int unsigned DATA_W       = c_DATA_W_DEFAULT,
    parameter int unsigned MAX_DISP_RUN = 4,
    parameter int unsigned TIMEOUT      = 64
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic [DATA_W-1:0] disp_rdata,
    output logic              disp_done,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_done,
    output logic              mem_start,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_done,
    output logic              timeout_err
);

    localparam int unsigned        c_RUN_W   = $clog2(MAX_DISP_RUN + 1);
    localparam logic [c_RUN_W-1:0] c_RUN_MAX = c_RUN_W'(MAX_DISP_RUN);

    arb_state_e         r_state;
    arb_state_e         w_state_next;
    arb_sel_e           w_grant_sel;
    logic [c_RUN_W-1:0] r_run_cnt;

    logic w_disp_wins, w_cpu_wins, w_grant;
    logic w_busy, w_finish, w_wd_expired, w_abort;
    logic w_disp_done_nxt, w_cpu_done_nxt;

    logic              r_mem_start, r_mem_we, r_disp_done, r_cpu_done, r_timeout_err;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata, r_disp_rdata, r_cpu_rdata;

    // Display keeps priority until it has won MAX_DISP_RUN times over a waiting CPU
    assign w_disp_wins = disp_req && (!cpu_req || (r_run_cnt < c_RUN_MAX));
    assign w_cpu_wins  = cpu_req && !w_disp_wins;
    assign w_busy      = (r_state == BUSY_DISP) || (r_state == BUSY_CPU);
    assign w_finish    = w_busy && (mem_done || w_wd_expired);

    arb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_clear   (w_finish),
        .i_enable  (w_busy),
        .o_expired (w_wd_expired)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_disp_wins) begin
                    w_state_next = BUSY_DISP;
                end else if (w_cpu_wins) begin
                    w_state_next = BUSY_CPU;
                end
            end
            BUSY_DISP, BUSY_CPU: begin
                if (w_finish) begin
                    w_state_next = COOL;
                end
            end
            COOL:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        w_grant         = 1'b0;
        w_grant_sel     = SEL_DISP;
        w_disp_done_nxt = 1'b0;
        w_cpu_done_nxt  = 1'b0;
        w_abort         = 1'b0;
        case (r_state)
            IDLE: begin
                w_grant     = w_disp_wins || w_cpu_wins;
                w_grant_sel = w_disp_wins ? SEL_DISP : SEL_CPU;
            end
            BUSY_DISP: begin
                w_disp_done_nxt = w_finish;
                w_abort         = w_finish && !mem_done;
            end
            BUSY_CPU: begin
                w_cpu_done_nxt = w_finish;
                w_abort        = w_finish && !mem_done;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mem_start   <= 1'b0;
            r_mem_we      <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_wdata   <= '0;
            r_disp_done   <= 1'b0;
            r_cpu_done    <= 1'b0;
            r_timeout_err <= 1'b0;
            r_disp_rdata  <= '0;
            r_cpu_rdata   <= '0;
            r_run_cnt     <= '0;
        end else begin
            r_mem_start   <= w_grant;
            r_disp_done   <= w_disp_done_nxt;
            r_cpu_done    <= w_cpu_done_nxt;
            r_timeout_err <= w_abort;

            if (w_grant) begin
                if (w_grant_sel == SEL_CPU) begin
                    r_mem_addr  <= cpu_addr;
                    r_mem_we    <= cpu_we;
                    r_mem_wdata <= cpu_wdata;
                    r_run_cnt   <= '0;
                end else begin
                    r_mem_addr  <= disp_addr;
                    r_mem_we    <= 1'b0;
                    r_mem_wdata <= '0;
                    if (!cpu_req) begin
                        r_run_cnt <= '0;
                    end else if (r_run_cnt != c_RUN_MAX) begin
                        r_run_cnt <= r_run_cnt + 1'b1;
                    end
                end
            end

            // An aborted transaction leaves the previous read data in place
            if (w_disp_done_nxt && mem_done) begin
                r_disp_rdata <= mem_rdata;
            end
            if (w_cpu_done_nxt && mem_done) begin
                r_cpu_rdata <= mem_rdata;
            end
        end
    end

    assign mem_start   = r_mem_start;
    assign mem_we      = r_mem_we;
    assign mem_addr    = r_mem_addr;
    assign mem_wdata   = r_mem_wdata;
    assign disp_done   = r_disp_done;
    assign cpu_done    = r_cpu_done;
    assign timeout_err = r_timeout_err;
    assign disp_rdata  = r_disp_rdata;
    assign cpu_rdata   = r_cpu_rdata;

endmodule
`default_nettype wire

// File: tb/tb_vram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_vram_port_arbiter
// Brief   : Scoreboard bench with requester agents and a controller model.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_vram_port_arbiter;
    import vram_arb_pkg::*;

    localparam int ADDR_W       = 16;
    localparam int DATA_W       = 16;
    localparam int MAX_DISP_RUN = 4;
    localparam int TIMEOUT      = 64;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              disp_req = 1'b0;
    logic [ADDR_W-1:0] disp_addr = '0;
    logic [DATA_W-1:0] disp_rdata;
    logic              disp_done;
    logic              cpu_req = 1'b0;
    logic              cpu_we = 1'b0;
    logic [ADDR_W-1:0] cpu_addr = '0;
    logic [DATA_W-1:0] cpu_wdata = '0;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_done;
    logic              mem_start;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic              mem_done = 1'b0;
    logic              timeout_err;

    vram_port_arbiter #(
        .ADDR_W       (ADDR_W),
        .DATA_W       (DATA_W),
        .MAX_DISP_RUN (MAX_DISP_RUN),
        .TIMEOUT      (TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .disp_req    (disp_req),
        .disp_addr   (disp_addr),
        .disp_rdata  (disp_rdata),
        .disp_done   (disp_done),
        .cpu_req     (cpu_req),
        .cpu_we      (cpu_we),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_rdata   (cpu_rdata),
        .cpu_done    (cpu_done),
        .mem_start   (mem_start),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_done    (mem_done),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        arb_sel_e    who;
        logic [15:0] addr;
        logic        we;
        logic [15:0] wdata;
        logic [15:0] rdata;   // value the controller model returns
        logic        tmo;     // controller withholds mem_done
        logic        chk_lat;
    } txn_t;

    txn_t        exp_q[$];
    txn_t        cur;
    int          n_vec = 0;
    int          n_miss = 0;
    int          cyc = 0;
    bit          outstanding = 1'b0;
    int          st_cyc = 0;
    int          done_drv_cyc = 0;
    int          late_cyc = -1;
    int          ctrl_lat = 3;
    int          disp_todo = 0;
    int          cpu_todo = 0;
    int          disp_rise = 0;
    int          cpu_rise = 0;
    int          n_starts = 0;
    logic [15:0] disp_shadow = '0;
    logic [15:0] cpu_shadow = '0;
    bit          cpu_shadow_ok = 1'b1;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    // Requester agents, controller model and scoreboard, all on the falling edge
    always @(negedge clk) begin
        txn_t e;
        cyc++;
        if (!reset_n) begin
            outstanding   = 1'b0;
            exp_q.delete();
            disp_todo     = 0;
            cpu_todo      = 0;
            disp_req      = 1'b0;
            cpu_req       = 1'b0;
            mem_done      = 1'b0;
            late_cyc      = -1;
            disp_shadow   = '0;
            cpu_shadow    = '0;
            cpu_shadow_ok = 1'b1;
        end else begin
            if (mem_start) begin
                n_starts++;
                check_value("overlap", 32'(outstanding), 32'd0);
                check_value("start_queued", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q[0];
                    check_value("grant_addr", 32'(mem_addr), 32'(e.addr));
                    check_value("grant_we_wd", 32'({mem_we, mem_wdata}), 32'({e.we, e.wdata}));
                    if (e.chk_lat)
                        check_value("start_lat", 32'(cyc - ((e.who == SEL_CPU) ? cpu_rise : disp_rise)), 32'd1);
                    cur         = e;
                    outstanding = 1'b1;
                    st_cyc      = cyc;
                end
            end

            if (disp_done || cpu_done) begin
                check_value("done_queued", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    outstanding = 1'b0;
                    check_value("done_who", 32'({disp_done, cpu_done}), (e.who == SEL_CPU) ? 32'd1 : 32'd2);
                    check_value("timeout_err", 32'(timeout_err), 32'(e.tmo));
                    if (e.tmo) begin
                        check_value("tmo_lat", 32'(cyc - st_cyc), 32'(TIMEOUT));
                        late_cyc = cyc + 1;
                    end else begin
                        check_value("done_lat", 32'(cyc - done_drv_cyc), 32'd1);
                    end
                    if (e.who == SEL_DISP) begin
                        check_value("disp_rdata", 32'(disp_rdata), 32'(e.tmo ? disp_shadow : e.rdata));
                        if (!e.tmo) disp_shadow = e.rdata;
                        disp_todo--;
                        if (disp_todo <= 0) disp_req = 1'b0;
                    end else begin
                        if (e.we && !e.tmo) begin
                            cpu_shadow_ok = 1'b0;
                        end else if (!e.tmo || cpu_shadow_ok) begin
                            check_value("cpu_rdata", 32'(cpu_rdata), 32'(e.tmo ? cpu_shadow : e.rdata));
                            if (!e.tmo) begin
                                cpu_shadow    = e.rdata;
                                cpu_shadow_ok = 1'b1;
                            end
                        end
                        cpu_todo--;
                        if (cpu_todo <= 0) cpu_req = 1'b0;
                    end
                end
            end else if (timeout_err) begin
                check_value("stray_tmo", 32'(timeout_err), 32'd0);
            end

            mem_done = 1'b0;
            if (outstanding && !cur.tmo && (cyc == st_cyc + ctrl_lat)) begin
                check_value("hold_we_addr", 32'({mem_we, mem_addr}), 32'({cur.we, cur.addr}));
                check_value("hold_wdata", 32'(mem_wdata), 32'(cur.wdata));
                mem_done     = 1'b1;
                mem_rdata    = cur.rdata;
                done_drv_cyc = cyc;
            end
            if (late_cyc == cyc) begin
                mem_done  = 1'b1;
                mem_rdata = 16'hDEAD;
            end

            if (disp_todo > 0 && !disp_req) begin
                disp_req  = 1'b1;
                disp_rise = cyc;
            end
            if (cpu_todo > 0 && !cpu_req) begin
                cpu_req  = 1'b1;
                cpu_rise = cyc;
            end
        end
    end

    function automatic txn_t mk(input arb_sel_e who, input logic [15:0] addr, input logic we,
                                input logic [15:0] wdata, input logic [15:0] rdata,
                                input logic tmo, input logic chk_lat);
        txn_t t;
        t.who = who; t.addr = addr; t.we = we; t.wdata = wdata;
        t.rdata = rdata; t.tmo = tmo; t.chk_lat = chk_lat;
        return t;
    endfunction

    task automatic wait_drain(input int bound);
        int n = 0;
        while ((exp_q.size() != 0 || outstanding || disp_todo > 0 || cpu_todo > 0) && n < bound) begin
            @(negedge clk);
            n++;
        end
        check_value("drained", 32'(exp_q.size() + disp_todo + cpu_todo), 32'd0);
        repeat (4) @(negedge clk);
    endtask

    initial begin
        int s0;
        repeat (3) @(negedge clk);
        check_value("rst_ctl", 32'({mem_start, mem_we, disp_done, cpu_done, timeout_err}), 32'd0);
        check_value("rst_mem", 32'({mem_addr, mem_wdata}), 32'd0);
        check_value("rst_rdata", 32'({disp_rdata, cpu_rdata}), 32'd0);
        reset_n = 1'b1;

        // Simultaneous first request: display first, then CPU
        disp_addr = 16'h0200; cpu_addr = 16'h4100; cpu_we = 1'b0; ctrl_lat = 3;
        exp_q.push_back(mk(SEL_DISP, 16'h0200, 1'b0, 16'h0000, 16'h1111, 1'b0, 1'b1));
        exp_q.push_back(mk(SEL_CPU,  16'h4100, 1'b0, 16'h0000, 16'h2222, 1'b0, 1'b0));
        disp_todo = 1; cpu_todo = 1;
        wait_drain(200);

        // Single CPU write, controller latency 10
        cpu_addr = 16'h4000; cpu_we = 1'b1; cpu_wdata = 16'hBEEF; ctrl_lat = 10;
        exp_q.push_back(mk(SEL_CPU, 16'h4000, 1'b1, 16'hBEEF, 16'h0000, 1'b0, 1'b1));
        cpu_todo = 1;
        wait_drain(200);

        // Single display read
        disp_addr = 16'h0123; ctrl_lat = 4;
        exp_q.push_back(mk(SEL_DISP, 16'h0123, 1'b0, 16'h0000, 16'h5A5A, 1'b0, 1'b1));
        disp_todo = 1;
        wait_drain(200);

        // Starvation bound: D,D,D,D,C repeated with both requests held
        disp_addr = 16'h1000; cpu_addr = 16'h4000; cpu_we = 1'b0; cpu_wdata = 16'h0; ctrl_lat = 3;
        for (int i = 0; i < 10; i++) begin
            if (i % 5 == 4)
                exp_q.push_back(mk(SEL_CPU, 16'h4000, 1'b0, 16'h0000, 16'h3000 + 16'(i), 1'b0, 1'b0));
            else
                exp_q.push_back(mk(SEL_DISP, 16'h1000, 1'b0, 16'h0000, 16'h3000 + 16'(i), 1'b0, 1'b0));
        end
        disp_todo = 8; cpu_todo = 2;
        wait_drain(400);

        // Watchdog abort on a CPU read, then a late mem_done
        cpu_addr = 16'h4ABC;
        exp_q.push_back(mk(SEL_CPU, 16'h4ABC, 1'b0, 16'h0000, 16'hFFFF, 1'b1, 1'b1));
        cpu_todo = 1;
        wait_drain(400);
        s0 = n_starts;
        repeat (6) @(negedge clk);
        check_value("late_done_quiet", 32'({n_starts - s0, 31'(cpu_rdata), cpu_done}), 32'({32'd0, 31'(cpu_shadow), 1'b0}));

        // Reset three cycles into a busy transaction
        cpu_addr = 16'h7777; cpu_wdata = 16'h1234; cpu_we = 1'b1;
        exp_q.push_back(mk(SEL_CPU, 16'h7777, 1'b1, 16'h1234, 16'h0000, 1'b1, 1'b0));
        cpu_todo = 1;
        for (int i = 0; i < 50 && !outstanding; i++) @(negedge clk);
        check_value("rst_txn_started", 32'(outstanding), 32'd1);
        repeat (3) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check_value("async_rst_ctl", 32'({mem_start, mem_we, disp_done, cpu_done, timeout_err}), 32'd0);
        check_value("async_rst_mem", 32'({mem_addr, mem_wdata}), 32'd0);
        check_value("async_rst_rdata", 32'({disp_rdata, cpu_rdata}), 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        s0 = n_starts;
        repeat (10) @(negedge clk);
        check_value("post_rst_quiet", 32'(n_starts - s0), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
